uart_tx_ctrl: RTL



---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_tx_ctrl_if.sv | 9 +
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX frame sequencer and the future RX sampler.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int DATA_BITS_BASE = 5;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
`ifdef UART_TX_BREAK_EN
        ,
        ST_BREAK
`endif
    } tx_state_t;

    // Bits at or above nbits are masked so a narrow frame ignores the byte's upper bits.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [3:0] nbits,
                                         input parity_t     ptype);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits)) begin
                acc = acc ^ data[i];
            end
        end
        case (ptype)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// FIFO pop handshake between the TX frame sequencer (master) and the tx_queue FIFO (slave).
interface uart_tx_ctrl_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_re;

    modport master (input fifo_empty, input fifo_dout, output fifo_re);
    modport slave  (output fifo_empty, output fifo_dout, input fifo_re);
endinterface

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks and flags the tick that closes each serial bit.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16,
    parameter int TICK_CNT_W = $clog2(OVERSAMPLE)
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic restart,
    output logic bit_end
);

    logic [TICK_CNT_W-1:0] cnt;
    logic                  at_last;

    assign at_last = (cnt == TICK_CNT_W'(OVERSAMPLE - 1));
    assign bit_end = tick && !restart && at_last;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add break_req and the BREAK (line held low) state.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int TICK_CNT_W = $clog2(OVERSAMPLE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    uart_tx_ctrl_if.master        fifo,
    input  logic [1:0]            data_bits_count,
    input  logic [1:0]            parity_type,
    input  logic                  double_stop_bits,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_req,
`endif
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    tx_state_t  state;
    logic [7:0] shift_reg;
    logic [1:0] dbc_q;
    parity_t    par_q;
    logic       dbl_q;
    logic       parity_bit;
    logic [2:0] bit_cnt;

    logic bit_end;
    logic restart;
    logic brk_start;
    logic load;
    logic last_bit;
    logic has_parity;

`ifdef UART_TX_BREAK_EN
    assign brk_start = (state == ST_IDLE) && break_req;
    assign restart   = (state == ST_IDLE) || (state == ST_BREAK);
`else
    assign brk_start = 1'b0;
    assign restart   = (state == ST_IDLE);
`endif

    assign load         = (state == ST_IDLE) && !fifo.fifo_empty && !brk_start;
    assign fifo.fifo_re = load;
    assign last_bit     = (bit_cnt == 3'(DATA_BITS_BASE - 1) + {1'b0, dbc_q});
    assign has_parity   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign frame_done   = bit_end && (((state == ST_STOP1) && !dbl_q) || (state == ST_STOP2));

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE),
        .TICK_CNT_W (TICK_CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .restart (restart),
        .bit_end (bit_end)
    );

    // Frame data and config snapshot; captured at the pop so mid-frame config edits wait for the next frame.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_reg  <= fifo.fifo_dout;
            dbc_q      <= data_bits_count;
            par_q      <= parity_t'(parity_type);
            dbl_q      <= double_stop_bits;
            parity_bit <= calc_parity(fifo.fifo_dout,
                                      4'(DATA_BITS_BASE) + {2'b00, data_bits_count},
                                      parity_t'(parity_type));
        end else if ((state == ST_DATA) && bit_end) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // tx is registered alongside the state so the line never sees a combinational input path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (brk_start) begin
                        state <= ST_BREAK;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
`endif
                    if (load) begin
                        state   <= ST_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                        tx    <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (!last_bit) begin
                            tx <= shift_reg[1];
                        end else if (has_parity) begin
                            state <= ST_PARITY;
                            tx    <= parity_bit;
                        end else begin
                            state <= ST_STOP1;
                            tx    <= 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP1;
                        tx    <= 1'b1;
                    end
                end
                ST_STOP1: begin
                    if (bit_end) begin
                        if (dbl_q) begin
                            state <= ST_STOP2;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_STOP2: begin
                    if (bit_end) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (!break_req) begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
